// File: rtl/ifc_or_sched.sv
// Round-robin front end sharing one ifc_or datapath (a/b in, y out) among NREQ requesters.
// One transaction is in flight at a time; a watchdog abandons transactions stuck in ISSUE/COLLECT.
module ifc_or_sched #(
  parameter int NREQ    = 2,
  parameter int DW      = 1,
  parameter int TIMEOUT = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    req_en,
  input  logic [NREQ*DW-1:0] req_a_data,
  input  logic [NREQ*DW-1:0] req_b_data,
  output logic [NREQ-1:0]    req_rdy,
  input  logic [NREQ-1:0]    resp_en,
  output logic [NREQ-1:0]    resp_rdy,
  output logic [DW-1:0]      resp_data,
  output logic               a_en,
  output logic [DW-1:0]      a_data,
  input  logic               a_rdy,
  output logic               b_en,
  output logic [DW-1:0]      b_data,
  input  logic               b_rdy,
  output logic               y_en,
  input  logic [DW-1:0]      y_data,
  input  logic               y_rdy,
  output logic               busy,
  output logic               timeout_err,
  output logic [15:0]        txn_count
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [PW-1:0] LAST  = PW'(NREQ - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, RESP} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic            r_a_done;
  logic            r_b_done;
  logic [TW-1:0]   r_tcnt;
  logic [DW-1:0]   r_a_op;
  logic [DW-1:0]   r_b_op;
  logic [DW-1:0]   r_resp_data;
  logic [15:0]     r_txn_count;
  logic            r_timeout_err;

  logic w_req_fire, w_a_fire, w_b_fire, w_issue_done, w_y_fire, w_resp_fire;
  logic w_advance, w_timeout;

  // With NREQ=1, LAST is 0 so the pointer never leaves 0.
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] x);
    return (x == LAST) ? '0 : x + 1'b1;
  endfunction

  assign w_req_fire   = (r_state == IDLE) && req_en[r_ptr];
  assign w_a_fire     = (r_state == ISSUE) && !r_a_done && a_rdy;
  assign w_b_fire     = (r_state == ISSUE) && !r_b_done && b_rdy;
  assign w_issue_done = (r_a_done || w_a_fire) && (r_b_done || w_b_fire);
  assign w_y_fire     = (r_state == COLLECT) && y_rdy;
  assign w_resp_fire  = (r_state == RESP) && resp_en[r_owner];
  assign w_advance    = ((r_state == ISSUE) && w_issue_done) || w_y_fire;
  // A cycle that completes its phase is never counted as a timeout.
  assign w_timeout    = ((r_state == ISSUE) || (r_state == COLLECT)) &&
                        (r_tcnt == TLAST) && !w_advance;

  assign a_en        = w_a_fire;
  assign b_en        = w_b_fire;
  assign y_en        = w_y_fire;
  assign a_data      = r_a_op;
  assign b_data      = r_b_op;
  assign resp_data   = r_resp_data;
  assign txn_count   = r_txn_count;
  assign timeout_err = r_timeout_err;
  assign busy        = (r_state != IDLE);

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_port
    assign req_rdy[gi]  = (r_state == IDLE) && (r_ptr == PW'(gi));
    assign resp_rdy[gi] = (r_state == RESP) && (r_owner == PW'(gi));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_owner       <= '0;
      r_a_done      <= 1'b0;
      r_b_done      <= 1'b0;
      r_tcnt        <= '0;
      r_a_op        <= '0;
      r_b_op        <= '0;
      r_resp_data   <= '0;
      r_txn_count   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      case (r_state)
        IDLE: begin
          if (w_req_fire) begin
            r_a_op   <= req_a_data[r_ptr*DW +: DW];
            r_b_op   <= req_b_data[r_ptr*DW +: DW];
            r_owner  <= r_ptr;
            r_a_done <= 1'b0;
            r_b_done <= 1'b0;
            r_tcnt   <= '0;
            r_state  <= ISSUE;
          end else begin
            r_ptr <= next_idx(r_ptr);
          end
        end
        ISSUE: begin
          r_tcnt <= r_tcnt + 1'b1;
          if (w_a_fire) r_a_done <= 1'b1;
          if (w_b_fire) r_b_done <= 1'b1;
          if (w_issue_done) begin
            r_state <= COLLECT;
          end else if (w_timeout) begin
            r_ptr   <= next_idx(r_owner);
            r_state <= IDLE;
          end
        end
        COLLECT: begin
          r_tcnt <= r_tcnt + 1'b1;
          if (w_y_fire) begin
            r_resp_data <= y_data;
            r_state     <= RESP;
          end else if (w_timeout) begin
            r_ptr   <= next_idx(r_owner);
            r_state <= IDLE;
          end
        end
        RESP: begin
          if (w_resp_fire) begin
            r_txn_count <= r_txn_count + 16'd1;
            r_ptr       <= next_idx(r_owner);
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ifc_or_sched.sv
// Directed scenarios plus a randomized phase for ifc_or_sched; the bench plays the OR datapath
// and tracks each transaction as owner plus expected a|b result.
module tb_ifc_or_sched;
  localparam int NREQ = 2, DW = 1, TIMEOUT = 16;

  logic CLK = 1'b0;
  logic RST;
  logic [NREQ-1:0] req_en, req_rdy, resp_en, resp_rdy;
  logic [NREQ*DW-1:0] req_a_data, req_b_data;
  logic [DW-1:0] resp_data, a_data, b_data, y_data;
  logic a_en, a_rdy, b_en, b_rdy, y_en, y_rdy, busy, timeout_err;
  logic [15:0] txn_count;

  int total = 0;
  int passed = 0;

  ifc_or_sched #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .req_en(req_en), .req_a_data(req_a_data), .req_b_data(req_b_data), .req_rdy(req_rdy),
    .resp_en(resp_en), .resp_rdy(resp_rdy), .resp_data(resp_data),
    .a_en(a_en), .a_data(a_data), .a_rdy(a_rdy),
    .b_en(b_en), .b_data(b_data), .b_rdy(b_rdy),
    .y_en(y_en), .y_data(y_data), .y_rdy(y_rdy),
    .busy(busy), .timeout_err(timeout_err), .txn_count(txn_count)
  );

  always #5 CLK = ~CLK;

  // Behavioural OR datapath: remembers operands on a/b fire, y is their OR.
  logic dp_a, dp_b;
  always @(posedge CLK) begin
    if (RST) begin
      dp_a <= 1'b0;
      dp_b <= 1'b0;
    end else begin
      if (a_en) dp_a <= a_data;
      if (b_en) dp_b <= b_data;
    end
  end
  assign y_data = dp_a | dp_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [1:0] oh(input int i);
    return 2'(1 << i);
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=hung expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int tout_at, saw_resp, ng, nr, lastg, g, pend, pend_owner, since, after_resp, ro, exp_txn, tout_seen;
    logic pend_data, frc;
    req_en = '0; req_a_data = '0; req_b_data = '0; resp_en = '0;
    a_rdy = 1'b1; b_rdy = 1'b1; y_rdy = 1'b1; RST = 1'b1;
    tick(); tick();
    RST = 1'b0; #1;
    check("rst_req_rdy", req_rdy, 2'b01);
    check("rst_busy", busy, 0);
    check("rst_a_en", a_en, 0);
    check("rst_b_en", b_en, 0);
    check("rst_y_en", y_en, 0);
    check("rst_resp_rdy", resp_rdy, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_txn", txn_count, 0);
    check("rst_tout", timeout_err, 0);

    // Single transaction: requester 0, a=1 b=0.
    req_en = 2'b01; req_a_data = 2'b01; req_b_data = 2'b00; #1;
    tick(); req_en = '0; #1;
    check("single_busy", busy, 1);
    check("single_a_en", a_en, 1);
    check("single_b_en", b_en, 1);
    check("single_a_data", a_data, 1);
    check("single_b_data", b_data, 0);
    check("single_req_rdy", req_rdy, 0);
    tick();
    check("single_y_en", y_en, 1);
    check("single_a_en_off", a_en, 0);
    tick();
    check("single_resp_rdy", resp_rdy, 2'b01);
    check("single_resp_data", resp_data, 1);
    check("single_txn_pre", txn_count, 0);
    resp_en = 2'b01; #1;
    tick(); resp_en = '0; #1;
    check("single_txn", txn_count, 1);
    check("single_idle", busy, 0);
    check("single_next_ptr", req_rdy, 2'b10);

    // Staggered rdy: requester 1, a=0 b=1, b_rdy low for three ISSUE cycles.
    req_en = 2'b10; req_a_data = 2'b00; req_b_data = 2'b10;
    a_rdy = 1'b1; b_rdy = 1'b0; y_rdy = 1'b0; #1;
    tick(); req_en = '0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) b_rdy = 1'b1;
      #1;
      check("stag_a_en", a_en, (k == 0) ? 1 : 0);
      check("stag_b_en", b_en, (k == 3) ? 1 : 0);
      tick();
    end
    y_rdy = 1'b1; #1;
    check("stag_collect_y_en", y_en, 1);
    check("stag_collect_b_en", b_en, 0);
    tick();

    // Response backpressure for five cycles.
    for (int k = 0; k < 5; k++) begin
      check("bp_resp_rdy", resp_rdy, 2'b10);
      check("bp_resp_data", resp_data, 1);
      check("bp_req_rdy", req_rdy, 0);
      tick();
    end
    resp_en = 2'b10; #1;
    tick(); resp_en = '0; #1;
    check("bp_txn", txn_count, 2);
    check("bp_next_ptr", req_rdy, 2'b01);

    // Timeout: y_rdy held low.
    req_en = 2'b01; req_a_data = 2'b01; req_b_data = 2'b01;
    a_rdy = 1'b1; b_rdy = 1'b1; y_rdy = 1'b0; #1;
    tick(); req_en = '0;
    tout_at = -1; saw_resp = 0;
    for (int k = 1; k <= 40 && tout_at < 0; k++) begin
      tick();
      if (resp_rdy != 0) saw_resp = 1;
      if (timeout_err) tout_at = k;
    end
    check("tout_cycle", tout_at, 16);
    check("tout_busy", busy, 0);
    check("tout_no_resp", saw_resp, 0);
    check("tout_txn", txn_count, 2);
    check("tout_next_ptr", req_rdy, 2'b10);
    tick();
    check("tout_pulse_end", timeout_err, 0);

    // Contention: both requesters hold en; offer pointer has rotated back to 0.
    req_en = 2'b11; req_a_data = 2'b00; req_b_data = 2'b10;
    a_rdy = 1'b1; b_rdy = 1'b1; y_rdy = 1'b1; resp_en = 2'b11;
    ng = 0; nr = 0; lastg = 0;
    for (int c = 0; c < 100 && nr < 4; c++) begin
      #1;
      if ((req_rdy & req_en) != 0) begin
        check("cont_grant", req_rdy & req_en, oh(ng % 2));
        lastg = (req_rdy[1]) ? 1 : 0;
        ng++;
      end
      if ((resp_rdy & resp_en) != 0) begin
        check("cont_resp_owner", resp_rdy, oh(lastg));
        check("cont_resp_data", resp_data, req_a_data[lastg] | req_b_data[lastg]);
        nr++;
      end
      tick();
    end
    req_en = '0; resp_en = '0;
    check("cont_done", nr, 4);
    check("cont_txn", txn_count, 6);

    // Randomized traffic against the transaction scoreboard.
    exp_txn = 6; pend = 0; pend_owner = 0; pend_data = 1'b0;
    since = 0; after_resp = 0; ro = 0; tout_seen = 0;
    for (int c = 0; c < 600; c++) begin
      if (after_resp != 0) begin
        check("rnd_txn", txn_count, exp_txn);
        check("rnd_next_ptr", req_rdy, oh((ro + 1) % NREQ));
        after_resp = 0;
      end
      frc = (pend != 0) && (since >= 4);
      req_en = 2'($urandom); req_a_data = 2'($urandom); req_b_data = 2'($urandom);
      resp_en = 2'($urandom);
      a_rdy = frc | 1'($urandom); b_rdy = frc | 1'($urandom); y_rdy = frc | 1'($urandom);
      #1;
      if ((req_rdy & req_en) != 0) begin
        g = (req_rdy[1]) ? 1 : 0;
        check("rnd_grant_when_free", pend, 0);
        pend = 1; pend_owner = g; since = 0;
        pend_data = req_a_data[g] | req_b_data[g];
      end
      if ((resp_rdy & resp_en) != 0) begin
        check("rnd_resp_owner", resp_rdy, oh(pend_owner));
        check("rnd_resp_data", resp_data, pend_data);
        pend = 0; exp_txn++; after_resp = 1; ro = pend_owner;
      end
      if (timeout_err) tout_seen++;
      tick();
      if (pend != 0) since++;
    end
    check("rnd_no_timeout", tout_seen, 0);

    // Drain, then reset while in COLLECT.
    req_en = '0; resp_en = 2'b11; a_rdy = 1'b1; b_rdy = 1'b1; y_rdy = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    req_en = 2'b11; resp_en = '0; y_rdy = 1'b0; #1;
    tick(); req_en = '0;
    tick();
    check("mid_busy_pre", busy, 1);
    check("mid_a_en_pre", a_en, 0);
    RST = 1'b1; #1;
    tick();
    y_rdy = 1'b1; #1;
    check("mid_busy", busy, 0);
    check("mid_req_rdy", req_rdy, 2'b01);
    check("mid_a_en", a_en, 0);
    check("mid_b_en", b_en, 0);
    check("mid_y_en", y_en, 0);
    check("mid_resp_rdy", resp_rdy, 0);
    check("mid_txn", txn_count, 0);
    RST = 1'b0;
    tick(); tick();
    check("mid_no_resp_after", resp_rdy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
